mpu_load: RTL

- Loads a matrix from an external memory source into the register file, one floating point element per accepted beat.
- Counterpart of the store path: external source --> register file.
- Captures the matrix size and destination address at request time, then arbitrates for the register file.
- Writes elements in row-major order at (i,j) locations; signals completion with a one-cycle done pulse.

---
 rtl/mpu_load_pkg.sv | 33 +++
 rtl/mpu_load.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/mpu_load_pkg.sv
// Shared widths, element type and load FSM states for the matrix load path.
// Holds the bounds helper used when MPU_LOAD_BOUNDS_CHECK_EN is defined.
package mpu_load_pkg;

  localparam int MBITS           = 3;
  localparam int NBITS           = 3;
  localparam int MATRIX_REG_BITS = 2;
  localparam int M               = 8;
  localparam int N               = 8;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef logic [31:0] float_sp;

  typedef enum logic [1:0] {
    LOAD_IDLE,
    LOAD_REQUEST,
    LOAD_MATRIX,
    LOAD_DONE
  } load_state_e;

  function automatic logic is_empty(input logic [MBITS:0] m_size,
                                    input logic [NBITS:0] n_size);
    return (m_size == '0) || (n_size == '0);
  endfunction

  function automatic logic out_of_bounds(input logic [MBITS:0] m_size,
                                         input logic [NBITS:0] n_size);
    return (m_size > (MBITS+1)'(M)) || (n_size > (NBITS+1)'(N));
  endfunction

endpackage

// File: rtl/mpu_load.sv
// Matrix load path: external memory beats are written row-major into the register file.
// Optional MPU_LOAD_BOUNDS_CHECK_EN adds load_err_out for empty or oversized requests.
module mpu_load
  import mpu_load_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       load_req_in,
  input  logic [MATRIX_REG_BITS:0]   mem_load_addr_in,
  input  logic [MBITS:0]             mem_m_load_size_in,
  input  logic [NBITS:0]             mem_n_load_size_in,
  input  logic                       mem_load_en_in,
  input  float_sp                    mem_load_element_in,
  output logic                       mem_load_ready_out,
  input  logic                       reg_load_ready_in,
  output logic                       reg_load_req_out,
  output logic                       reg_load_en_out,
  output float_sp                    reg_load_element_out,
  output logic [MBITS:0]             reg_i_load_loc_out,
  output logic [NBITS:0]             reg_j_load_loc_out,
  output logic [MATRIX_REG_BITS:0]   reg_load_addr_out,
  output logic [MBITS:0]             reg_m_load_size_out,
  output logic [NBITS:0]             reg_n_load_size_out,
  output logic                       load_busy_out,
  output logic                       load_done_out
`ifdef MPU_LOAD_BOUNDS_CHECK_EN
  , output logic                     load_err_out
`endif
);

  load_state_e              r_state;
  load_state_e              w_next;
  logic [MBITS:0]           r_row;
  logic [NBITS:0]           r_col;
  logic [MATRIX_REG_BITS:0] r_addr;
  logic [MBITS:0]           r_m;
  logic [NBITS:0]           r_n;
  logic                     w_bad;
  logic                     w_beat;
  logic                     w_row_end;
  logic                     w_col_end;
  logic                     w_last;

`ifdef MPU_LOAD_BOUNDS_CHECK_EN
  logic r_err;
  assign w_bad = is_empty(mem_m_load_size_in, mem_n_load_size_in) ||
                 out_of_bounds(mem_m_load_size_in, mem_n_load_size_in);
  assign load_err_out = r_err && (r_state == LOAD_DONE);
`else
  assign w_bad = is_empty(mem_m_load_size_in, mem_n_load_size_in);
`endif

  assign w_beat    = (r_state == LOAD_MATRIX) && mem_load_en_in;
  assign w_row_end = (r_row == r_m - (MBITS+1)'(1));
  assign w_col_end = (r_col == r_n - (NBITS+1)'(1));
  assign w_last    = w_beat && w_row_end && w_col_end;

  assign reg_load_addr_out   = r_addr;
  assign reg_m_load_size_out = r_m;
  assign reg_n_load_size_out = r_n;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= LOAD_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_row  <= '0;
      r_col  <= '0;
      r_addr <= '0;
      r_m    <= '0;
      r_n    <= '0;
`ifdef MPU_LOAD_BOUNDS_CHECK_EN
      r_err  <= FALSE;
`endif
    end else begin
      case (r_state)
        LOAD_IDLE: begin
          if (load_req_in) begin
            r_addr <= mem_load_addr_in;
            r_m    <= mem_m_load_size_in;
            r_n    <= mem_n_load_size_in;
`ifdef MPU_LOAD_BOUNDS_CHECK_EN
            r_err  <= w_bad;
`endif
          end
        end
        LOAD_REQUEST: begin
          if (reg_load_ready_in) begin
            r_row <= '0;
            r_col <= '0;
          end
        end
        LOAD_MATRIX: begin
          // The last beat leaves the pointers parked on the final element.
          if (w_beat && !w_last) begin
            if (w_col_end) begin
              r_col <= '0;
              r_row <= r_row + (MBITS+1)'(1);
            end else begin
              r_col <= r_col + (NBITS+1)'(1);
            end
          end
        end
        LOAD_DONE: begin
          r_row <= '0;
          r_col <= '0;
        end
        default: begin
          r_row <= '0;
          r_col <= '0;
        end
      endcase
    end
  end

  always_comb begin
    w_next               = r_state;
    mem_load_ready_out   = FALSE;
    reg_load_req_out     = FALSE;
    reg_load_en_out      = FALSE;
    reg_load_element_out = '0;
    reg_i_load_loc_out   = '0;
    reg_j_load_loc_out   = '0;
    load_busy_out        = TRUE;
    load_done_out        = FALSE;
    case (r_state)
      LOAD_IDLE: begin
        load_busy_out = FALSE;
        if (load_req_in) begin
          w_next = w_bad ? LOAD_DONE : LOAD_REQUEST;
        end
      end
      LOAD_REQUEST: begin
        reg_load_req_out = TRUE;
        if (reg_load_ready_in) begin
          w_next = LOAD_MATRIX;
        end
      end
      LOAD_MATRIX: begin
        reg_load_req_out     = TRUE;
        mem_load_ready_out   = TRUE;
        reg_load_en_out      = mem_load_en_in;
        reg_load_element_out = mem_load_element_in;
        reg_i_load_loc_out   = r_row;
        reg_j_load_loc_out   = r_col;
        if (w_last) begin
          w_next = LOAD_DONE;
        end
      end
      LOAD_DONE: begin
        load_done_out = TRUE;
        w_next        = LOAD_IDLE;
      end
      default: begin
        w_next = LOAD_IDLE;
      end
    endcase
  end

endmodule
